// File: rtl/sipo_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_deserializer_pkg
// Purpose  : Bit-order encoding and the constant clog2 helper for the deserializer.
// Revision : 1.0 - initial release
// ============================================================================
package sipo_deserializer_pkg;

  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } order_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >>> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_shift_core.sv
`default_nettype none
// ============================================================================
// Module   : sipo_shift_core
// Purpose  : Bidirectional serial-in shift register with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_shift_core
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             serial_in,
  input  order_e           order,
  output logic [WIDTH-1:0] word
);

  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_shifted;

  // A clear coinciding with a shift starts a fresh word with that bit.
  assign w_base = clr ? '0 : r_word;

  generate
    if (WIDTH == 1) begin : g_single
      assign w_shifted = serial_in;
    end else begin : g_multi
      assign w_shifted = (order == ORDER_MSB_FIRST) ? {w_base[WIDTH-2:0], serial_in}
                                                    : {serial_in, w_base[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
    end else if (shift_en) begin
      r_word <= w_shifted;
    end else if (clr) begin
      r_word <= '0;
    end
  end

  assign word = r_word;

endmodule
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : sipo_deserializer
// Purpose  : Serial-to-parallel word assembly with valid/ready output and overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_sync,
  input  logic             shift_en,
  input  logic             serial_in,
  input  logic             msb_first,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [CNT_W-1:0] c_last   = CNT_W'(WIDTH - 1);
  localparam bit               c_single = (WIDTH == 1);

  logic [CNT_W-1:0] r_bit_cnt;
  order_e           r_order;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_overrun;

  logic             w_first;
  order_e           w_order;
  logic             w_complete;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_candidate;

  assign w_first    = shift_en && (frame_sync || (r_bit_cnt == '0));
  assign w_order    = w_first ? order_e'(msb_first) : r_order;
  // A resync edge only completes a word when a single bit is a whole word.
  assign w_complete = shift_en && (r_bit_cnt == c_last) && (!frame_sync || c_single);

  sipo_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .clr       (frame_sync || w_complete),
    .shift_en  (shift_en && !w_complete),
    .serial_in (serial_in),
    .order     (w_order),
    .word      (w_word)
  );

  generate
    if (WIDTH == 1) begin : g_single
      assign w_candidate = serial_in;
    end else begin : g_multi
      assign w_candidate = (w_order == ORDER_MSB_FIRST) ? {w_word[WIDTH-2:0], serial_in}
                                                        : {serial_in, w_word[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_order     <= ORDER_LSB_FIRST;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (frame_sync) begin
        r_bit_cnt <= (shift_en && !c_single) ? CNT_W'(1) : '0;
      end else if (shift_en) begin
        r_bit_cnt <= w_complete ? '0 : r_bit_cnt + CNT_W'(1);
      end

      if (w_first) begin
        r_order <= order_e'(msb_first);
      end

      if (w_complete && (!r_out_valid || out_ready)) begin
        r_out_data  <= w_candidate;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (frame_sync) begin
        r_overrun <= 1'b0;
      end else if (w_complete && r_out_valid && !out_ready) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign bit_cnt   = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_deserializer
// Purpose  : Scoreboard bench for the WIDTH=8 and WIDTH=1 deserializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       fs, se, si, mf, rdy;
  logic [7:0] d8;
  logic       v8, ov8;
  logic [3:0] cnt8;
  logic       fs1, se1, si1, mf1, rdy1;
  logic [0:0] d1;
  logic       v1, ov1;
  logic [0:0] cnt1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic       exp1_q[$];

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .frame_sync(fs), .shift_en(se), .serial_in(si),
    .msb_first(mf), .out_ready(rdy), .out_data(d8), .out_valid(v8),
    .overrun(ov8), .bit_cnt(cnt8)
  );

  sipo_deserializer #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .frame_sync(fs1), .shift_en(se1), .serial_in(si1),
    .msb_first(mf1), .out_ready(rdy1), .out_data(d1), .out_valid(v1),
    .overrun(ov1), .bit_cnt(cnt1)
  );

  // seq[7] is the first bit on the wire
  function automatic logic [7:0] assemble(input logic [7:0] seq, input logic msb);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = seq[7-k];
    return msb ? seq : r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (d8 !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", d8); end
    checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", v8); end
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", ov8); end
    checks++; if (cnt8 !== 4'd0) begin errors++; $display("FAIL reset_bit_cnt: got %0d expected 0", cnt8); end
    checks++; if (v1 !== 1'b0 || ov1 !== 1'b0) begin errors++; $display("FAIL reset_w1: got v=%b ov=%b expected 0 0", v1, ov1); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_lsb_first();
    logic [7:0] seq;
    seq = 8'b1011_0010;
    rdy = 1'b1; fs = 1'b0;
    exp_q.push_back(assemble(seq, 1'b0));
    for (int i = 0; i < 8; i++) begin
      se = 1'b1; si = seq[7-i]; mf = 1'b0;
      checks++; if (cnt8 !== 4'(i)) begin errors++; $display("FAIL lsb_bit_cnt: got %0d expected %0d", cnt8, i); end
      if (i == 7) begin
        checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL lsb_early_valid: got %b expected 0", v8); end
      end
      tick();
    end
    se = 1'b0;
    checks++; if (v8 !== 1'b1) begin errors++; $display("FAIL lsb_valid: got %b expected 1", v8); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL lsb_data: got %h expected none", d8); end
    else begin
      if (d8 !== exp_q[0]) begin errors++; $display("FAIL lsb_data: got %h expected %h", d8, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    tick();
    checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL lsb_valid_drop: got %b expected 0", v8); end
  endtask

  task automatic test_msb_toggle();
    logic [7:0] seq;
    seq = 8'b1011_0010;
    rdy = 1'b1;
    exp_q.push_back(assemble(seq, 1'b1));
    for (int i = 0; i < 8; i++) begin
      se = 1'b1; si = seq[7-i]; mf = (i < 3);
      tick();
      checks++; if (cnt8 !== 4'((i + 1) % 8)) begin errors++; $display("FAIL msb_bit_cnt: got %0d expected %0d", cnt8, (i + 1) % 8); end
    end
    se = 1'b0;
    checks++;
    if (!v8 || exp_q.size() == 0) begin errors++; $display("FAIL msb_data: got valid %b expected 1", v8); end
    else begin
      if (d8 !== exp_q[0]) begin errors++; $display("FAIL msb_data: got %h expected %h", d8, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq;
    seq = {8'hA5, 8'h3C};
    exp_q.push_back(assemble(8'hA5, 1'b1));
    exp_q.push_back(assemble(8'h3C, 1'b1));
    for (int i = 0; i < 16; i++) begin
      se = 1'b1; si = seq[15-i]; mf = 1'b1;
      rdy = (i < 8) || (i == 15);
      if (v8 && rdy) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra: got %h expected none", d8); end
        else begin
          if (d8 !== exp_q[0]) begin errors++; $display("FAIL b2b_data: got %h expected %h", d8, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      tick();
    end
    se = 1'b0;
    checks++; if (v8 !== 1'b1) begin errors++; $display("FAIL b2b_boundary_valid: got %b expected 1", v8); end
    for (int i = 0; i < 3; i++) begin
      if (v8 && rdy) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra: got %h expected none", d8); end
        else begin
          if (d8 !== exp_q[0]) begin errors++; $display("FAIL b2b_data: got %h expected %h", d8, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      tick();
    end
    checks++; if (exp_q.size() != 0 || v8 !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0d pending valid %b expected 0 0", exp_q.size(), v8); end
  endtask

  task automatic test_overrun();
    logic [15:0] seq;
    seq = {8'h11, 8'h22};
    rdy = 1'b0;
    exp_q.push_back(8'h11);
    for (int i = 0; i < 16; i++) begin
      se = 1'b1; si = seq[15-i]; mf = 1'b1;
      if (i == 8) begin
        checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b expected 0", ov8); end
      end
      tick();
    end
    se = 1'b0;
    checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", ov8); end
    checks++; if (d8 !== 8'h11 || v8 !== 1'b1) begin errors++; $display("FAIL ovr_hold: got %h/%b expected 11/1", d8, v8); end
    rdy = 1'b1;
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL ovr_data: got %h expected none", d8); end
    else begin
      if (d8 !== exp_q[0]) begin errors++; $display("FAIL ovr_data: got %h expected %h", d8, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    tick(); tick();
    checks++; if (v8 !== 1'b0 || ov8 !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got v=%b ov=%b expected 0 1", v8, ov8); end
    fs = 1'b1;
    tick();
    fs = 1'b0;
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", ov8); end
  endtask

  task automatic test_resync();
    logic [7:0] seq;
    // a pending word so the sync edge can be seen leaving out_valid alone
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      se = 1'b1; si = 1'(8'h5A >> (7 - i)); mf = 1'b1;
      tick();
    end
    exp_q.push_back(8'h5A);
    for (int i = 0; i < 3; i++) begin
      se = 1'b1; si = 1'b1; mf = 1'b1;
      tick();
    end
    seq = 8'b1100_1011;
    exp_q.push_back(assemble(seq, 1'b0));
    fs = 1'b1; se = 1'b1; si = seq[7]; mf = 1'b0;
    tick();
    fs = 1'b0;
    checks++; if (cnt8 !== 4'd1) begin errors++; $display("FAIL sync_bit_cnt: got %0d expected 1", cnt8); end
    checks++; if (v8 !== 1'b1 || d8 !== 8'h5A) begin errors++; $display("FAIL sync_out: got %h/%b expected 5a/1", d8, v8); end
    rdy = 1'b1;
    for (int i = 1; i < 11; i++) begin
      se = (i < 8); si = (i < 8) ? seq[7-i] : 1'b0; mf = 1'b1;
      if (v8 && rdy) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL sync_extra: got %h expected none", d8); end
        else begin
          if (d8 !== exp_q[0]) begin errors++; $display("FAIL sync_data: got %h expected %h", d8, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      tick();
    end
    checks++; if (exp_q.size() != 0 || ov8 !== 1'b0) begin errors++; $display("FAIL sync_drain: got %0d pending ov %b expected 0 0", exp_q.size(), ov8); end
  endtask

  task automatic test_async_reset();
    rdy = 1'b0;
    for (int i = 0; i < 13; i++) begin
      se = 1'b1; si = 1'(8'h77 >> (i % 8)); mf = 1'b0;
      tick();
    end
    se = 1'b0;
    checks++; if (cnt8 !== 4'd5 || v8 !== 1'b1) begin errors++; $display("FAIL arst_setup: got cnt %0d v %b expected 5 1", cnt8, v8); end
    #2 rst = 1'b1;
    #1;
    checks++; if (d8 !== 8'h00 || v8 !== 1'b0 || ov8 !== 1'b0 || cnt8 !== 4'd0) begin
      errors++; $display("FAIL arst_outputs: got %h/%b/%b/%0d expected 00/0/0/0", d8, v8, ov8, cnt8);
    end
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_width1();
    logic [2:0] bits;
    bits = 3'b101;
    rdy1 = 1'b1; fs1 = 1'b0; mf1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      se1 = (i < 3); si1 = (i < 3) ? bits[2-i] : 1'b0;
      if (i < 3) exp1_q.push_back(bits[2-i]);
      if (v1 && rdy1) begin
        checks++;
        if (exp1_q.size() == 0) begin errors++; $display("FAIL w1_extra: got %b expected none", d1); end
        else begin
          if (d1[0] !== exp1_q[0]) begin errors++; $display("FAIL w1_data: got %b expected %b", d1[0], exp1_q[0]); end
          void'(exp1_q.pop_front());
        end
      end
      tick();
      checks++; if (cnt1 !== 1'b0) begin errors++; $display("FAIL w1_bit_cnt: got %0d expected 0", cnt1); end
    end
    checks++; if (exp1_q.size() != 0 || v1 !== 1'b0) begin errors++; $display("FAIL w1_drain: got %0d pending v %b expected 0 0", exp1_q.size(), v1); end
    rdy1 = 1'b0; se1 = 1'b1; si1 = 1'b1;
    tick();
    si1 = 1'b0;
    tick();
    checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL w1_overrun: got %b expected 1", ov1); end
    fs1 = 1'b1; se1 = 1'b1; si1 = 1'b0;
    tick();
    fs1 = 1'b0; se1 = 1'b0;
    checks++; if (ov1 !== 1'b0 || v1 !== 1'b1 || d1 !== 1'b1) begin
      errors++; $display("FAIL w1_sync_drop: got ov %b v %b d %b expected 0 1 1", ov1, v1, d1);
    end
    rdy1 = 1'b1;
    tick();
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL w1_final_valid: got %b expected 0", v1); end
  endtask

  initial begin
    rst = 1'b1;
    fs = 0; se = 0; si = 0; mf = 0; rdy = 0;
    fs1 = 0; se1 = 0; si1 = 0; mf1 = 0; rdy1 = 0;
    #12;
    test_reset();
    test_lsb_first();
    test_msb_toggle();
    test_back_to_back();
    test_overrun();
    test_resync();
    test_async_reset();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
